// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte port into a small circular FIFO,
// serialised LSB-first at BAUD_DIVIDER clocks per bit with no gap between queued frames.
module uart_tx_fifo #(
   parameter int unsigned BAUD_DIVIDER = 868,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                               clk_i,
   input  logic                               arst_i,
   input  logic                               wr_en_i,
   input  logic [7:0]                         wr_data_i,
   output logic                               wr_rdy_o,
   output logic                               tx_o,
   output logic                               busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BAUD_W = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIVIDER - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shreg_q, shreg_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               wr_rdy_q, wr_rdy_d;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               push;
   logic               pop;
   logic               bit_end;
   logic               fifo_nonempty;

   assign push          = wr_en_i & wr_rdy_q;
   assign bit_end       = (baud_q == BAUD_LAST);
   assign fifo_nonempty = (count_q != '0);

   // Frame sequencer: baud counter restarts on every state entry and every data bit.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shreg_d = mem_q[rd_ptr_q];
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shreg_d = mem_q[rd_ptr_q];
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level follows the state being entered so tx_o is registered without added latency.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shreg_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // FIFO occupancy and derived status flags.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      wr_rdy_d = (count_d != CNT_FULL);
      busy_d   = (state_d != ST_IDLE) | (count_d != '0);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         wr_rdy_q <= 1'b1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         wr_rdy_q <= wr_rdy_d;
         count_q  <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: occupancy is tracked entirely by count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign wr_rdy_o     = wr_rdy_q;
   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level expectations built from byte values, plus a
// line-decoding receiver whose output is compared against the queue of accepted bytes.
module tb_uart_tx_fifo;

   localparam int unsigned BAUD  = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             arst;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             wr_rdy;
   logic             tx;
   logic             busy;
   logic [CNT_W-1:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];

   bit         mon_active = 1'b0;
   int         mon_t = 0;
   logic [7:0] mon_b = '0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .BAUD_DIVIDER (BAUD),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i        (clk),
      .arst_i       (arst),
      .wr_en_i      (wr_en),
      .wr_data_i    (wr_data),
      .wr_rdy_o     (wr_rdy),
      .tx_o         (tx),
      .busy_o       (busy),
      .fifo_count_o (fifo_count)
   );

   // Line level of bit k (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   // Receiver: samples mid-bit on the falling clock edge, abandons a frame on reset.
   always @(negedge clk) begin
      if (arst === 1'b1) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_t      = 0;
         end
      end else begin
         mon_t++;
         if (mon_t == BAUD / 2) begin
            n_checks++;
            if (tx !== 1'b0) begin
               n_fail++;
               $display("FAIL rx_start_bit: tx=%b required 0 at %0t", tx, $time);
            end
         end else if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0) begin
            mon_b[3'((mon_t - 6) / 4)] = tx;
         end else if (mon_t == 38) begin
            n_checks++;
            if (tx !== 1'b1) begin
               n_fail++;
               $display("FAIL rx_stop_bit: tx=%b required 1 at %0t", tx, $time);
            end
            rx_q.push_back(mon_b);
            mon_active = 1'b0;
         end
      end
   end

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && !mon_active) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      arst    = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (tx !== 1'b1)     begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
      n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b required 1", wr_rdy); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (fifo_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
      arst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      bit ok;
      b = 8'hA5;
      rx_q.delete();
      for (int c = 0; c <= 41; c++) begin
         wr_en   = (c == 0);
         wr_data = b;
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (fifo_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_count: got %0d required 1", fifo_count); end
         end
         if (c >= 1 && c <= 40) begin
            n_checks++;
            if (tx !== frame_bit(b, (c - 1) / 4)) begin
               n_fail++; $display("FAIL single_tx cycle %0d: got %b required %b", c - 1, tx, frame_bit(b, (c - 1) / 4));
            end
         end
         if (c == 40) begin
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b required 1", busy); end
         end
         if (c == 41) begin
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b required 0", busy); end
         end
      end
      wr_en = 1'b0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle_timeout: busy=%b required 0", busy); end
      n_checks++;
      if (rx_q.size() != 1 || rx_q[0] !== b) begin
         n_fail++; $display("FAIL single_rx: got %0d bytes first %h required 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
      end
   endtask

   task automatic test_burst();
      logic [7:0] bytes [5];
      int j;
      bit ok;
      for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
      rx_q.delete();
      for (int c = 0; c <= 201; c++) begin
         wr_en   = (c < 5);
         wr_data = (c < 5) ? bytes[c] : 8'h00;
         @(negedge clk);
         if (c == 4) begin
            n_checks++;
            if (fifo_count !== CNT_W'(4)) begin n_fail++; $display("FAIL burst_count: got %0d required 4", fifo_count); end
            n_checks++;
            if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL burst_full: wr_rdy=%b required 0", wr_rdy); end
         end
         if (c >= 1 && c <= 200) begin
            j = c - 1;
            n_checks++;
            if (tx !== frame_bit(bytes[j / 40], (j % 40) / 4)) begin
               n_fail++; $display("FAIL burst_tx cycle %0d: got %b required %b", j, tx, frame_bit(bytes[j / 40], (j % 40) / 4));
            end
         end
         if (c == 201) begin
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_fall: got %b required 0", busy); end
         end
      end
      wr_en = 1'b0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_idle_timeout: busy=%b required 0", busy); end
      n_checks++;
      if (rx_q.size() != 5) begin n_fail++; $display("FAIL burst_rx_len: got %0d required 5", rx_q.size()); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i >= rx_q.size() || rx_q[i] !== bytes[i]) begin
            n_fail++; $display("FAIL burst_rx[%0d]: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, bytes[i]);
         end
      end
   endtask

   task automatic test_full_drop();
      logic [7:0] b [7];
      int m;
      bit ok;
      for (int i = 0; i < 7; i++) b[i] = 8'($urandom_range(0, 255));
      rx_q.delete();
      exp_q.delete();
      wr_en   = 1'b1;
      wr_data = b[0];
      exp_q.push_back(b[0]);
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      m = 0;
      for (int i = 1; i < 7; i++) begin
         n_checks++;
         if (wr_rdy !== (m < DEPTH)) begin
            n_fail++; $display("FAIL drop_wr_rdy write %0d: got %b required %b", i, wr_rdy, (m < DEPTH));
         end
         if (m < DEPTH) begin
            m++;
            exp_q.push_back(b[i]);
         end
         wr_en   = 1'b1;
         wr_data = b[i];
         @(negedge clk);
         n_checks++;
         if (fifo_count !== CNT_W'(m)) begin
            n_fail++; $display("FAIL drop_count write %0d: got %0d required %0d", i, fifo_count, m);
         end
      end
      wr_en = 1'b0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_idle_timeout: busy=%b required 0", busy); end
      n_checks++;
      if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_rx_len: got %0d required %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL drop_rx[%0d]: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_collision();
      logic [7:0] b [3];
      bit ok;
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom_range(0, 255));
      rx_q.delete();
      for (int c = 0; c <= 42; c++) begin
         wr_en   = (c == 0) || (c == 5) || (c == 41);
         wr_data = (c == 0) ? b[0] : (c == 5) ? b[1] : b[2];
         @(negedge clk);
         if (c == 5 || c == 40 || c == 41) begin
            n_checks++;
            if (fifo_count !== CNT_W'(1)) begin
               n_fail++; $display("FAIL collide_count cycle %0d: got %0d required 1", c, fifo_count);
            end
         end
         if (c == 41) begin
            n_checks++;
            if (tx !== 1'b0) begin n_fail++; $display("FAIL collide_next_start: tx=%b required 0", tx); end
         end
      end
      wr_en = 1'b0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL collide_idle_timeout: busy=%b required 0", busy); end
      n_checks++;
      if (rx_q.size() != 3) begin n_fail++; $display("FAIL collide_rx_len: got %0d required 3", rx_q.size()); end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= rx_q.size() || rx_q[i] !== b[i]) begin
            n_fail++; $display("FAIL collide_rx[%0d]: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, b[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b0, b1;
      bit saw_low;
      b0 = 8'($urandom_range(0, 255)) & 8'hF7;
      b1 = 8'($urandom_range(0, 255));
      rx_q.delete();
      for (int c = 0; c <= 18; c++) begin
         wr_en   = (c <= 1);
         wr_data = (c == 0) ? b0 : b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      n_checks++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: tx=%b required 0", tx); end
      arst = 1'b1;
      #1;
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b required 1", tx); end
      n_checks++; if (fifo_count !== CNT_W'(0)) begin n_fail++; $display("FAIL rstmid_count: got %0d required 0", fifo_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      @(negedge clk);
      arst    = 1'b0;
      saw_low = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      n_checks++; if (saw_low) begin n_fail++; $display("FAIL rstmid_quiet: tx went low=%b required 0", saw_low); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b required 0", busy); end
      n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_rx_len: got %0d required 0", rx_q.size()); end
   endtask

   task automatic test_pointer_wrap();
      int idx, n;
      bit ok;
      rx_q.delete();
      idx = 0;
      while (idx < 9) begin
         n = int'($urandom_range(1, 3));
         if (idx + n > 9) n = 9 - idx;
         for (int k = 0; k < n; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(idx);
            idx++;
            @(negedge clk);
         end
         wr_en = 1'b0;
         wait_idle(ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_idle_timeout at byte %0d: busy=%b required 0", idx, busy); end
      end
      n_checks++;
      if (rx_q.size() != 9) begin n_fail++; $display("FAIL wrap_rx_len: got %0d required 9", rx_q.size()); end
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (i >= rx_q.size() || rx_q[i] !== 8'(i)) begin
            n_fail++; $display("FAIL wrap_rx[%0d]: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i));
         end
      end
   endtask

   initial begin
      arst    = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      test_reset();
      test_single_byte();
      test_burst();
      test_full_drop();
      test_collision();
      test_reset_mid_frame();
      test_pointer_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter: the transmit end of the serial link on the board UART pins, driving the host's receive line. It accepts bytes through a valid/ready write port into a small FIFO and serialises them LSB-first at a fixed baud rate. It serves as the SoC-side transmitter and as the host-model transmitter in board-level benches that feed the SoC `rx_i`.

## Interface
- `BAUD_DIVIDER`, default 868: clock cycles per UART bit; 868 gives 115200 baud at 100 MHz; legal range ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries; power of two, ≥ 2.

- `clk_i`  in  1  single clock, rising edge.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `wr_en_i`  in  1  write request; byte accepted on an edge where `wr_en_i & wr_rdy_o`.
- `wr_data_i`  in  8  byte to transmit.
- `wr_rdy_o`  out  1  FIFO not full; registered.
- `tx_o`  out  1  serial line, idle high; registered.
- `busy_o`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH+1)  bytes stored, excluding the byte in flight.

## Operation
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH), wrapping modulo FIFO_DEPTH, plus a count register.
- FIFO full: count == FIFO_DEPTH and `wr_rdy_o` = 0. A write while `wr_rdy_o` = 0 is dropped silently, with no state change.
- FSM states and transitions:
  - IDLE: `tx_o` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx_o` = 0 for BAUD_DIVIDER cycles, then go to DATA.
  - DATA: 8 bits, LSB first, BAUD_DIVIDER cycles each. A 3-bit counter tracks the bit index; after bit 7 go to STOP.
  - STOP: `tx_o` = 1 for BAUD_DIVIDER cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: counts 0..BAUD_DIVIDER-1 and restarts at every state entry. A bit ends when the count reaches BAUD_DIVIDER-1.
- Simultaneous push and pop on one edge: count is unchanged, both pointers advance, and both operations take effect. A push into an empty FIFO on the same edge the FSM samples empty is popped on the next edge, not the same one.
- `busy_o` = (state != IDLE) | (count != 0).
- Reset mid-frame: the frame is aborted, `tx_o` goes high immediately, and the FIFO is emptied. No partial frame resumes.

## Timing
- Reset values: `tx_o` = 1, `wr_rdy_o` = 1, `busy_o` = 0, `fifo_count_o` = 0, state IDLE, pointers 0.
- Byte written at edge N into an empty FIFO while IDLE:
  - Count becomes 1 after edge N.
  - Pop at edge N+1; `tx_o` falls after edge N+1.
- Frame length: exactly 10·BAUD_DIVIDER cycles from start-bit fall to the end of the stop bit.
- Back-to-back frames: the next start bit follows the previous stop bit's last cycle with no extra cycle.
- `wr_rdy_o` reasserts the cycle after the edge on which a pop frees an entry.
- Throughput: one byte per 10·BAUD_DIVIDER cycles, sustained.

## Test plan
All scenarios use BAUD_DIVIDER = 4 and FIFO_DEPTH = 4.
- Single byte: reset, write 0xA5 at edge N -> `tx_o` low from edge N+1 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, high stop bit for 4 cycles. `busy_o` falls after 40 cycles.
- Burst: write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges -> first four accepted. The fifth is accepted because the pop of 0x01 at edge N+1 frees an entry before the fifth write. Five frames are sent contiguously, 200 cycles total, with no idle high between stop and start.
- Full drop: hold the FSM mid-frame and write 6 bytes -> `wr_rdy_o` = 0 once count = 4. Extra writes are dropped, and only the accepted bytes appear on `tx_o`.
- Push/pop collision: with count = 1 and the stop bit ending, write on the pop edge -> count stays 1 and byte order is preserved.
- Reset mid-frame: assert `arst_i` during DATA bit 3 -> `tx_o` = 1 and `fifo_count_o` = 0 immediately, with no frame after release until a new write.
- Pointer wrap: write and transmit 9 bytes, 0x00–0x08, in small batches -> every byte is received in order across pointer wrap.
